// File: rtl/trap_controller_pkg.sv
// Purpose: shared CSR addresses, CSR op codes, cause codes and bit positions for the trap unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_controller_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // funct3[1:0]; funct3[2] only selects the immediate form, which the datapath has already resolved
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Interrupt cause codes (low bits of mcause)
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  // Bit positions in mstatus and in mie/mip
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MEI      = 11;
  localparam int IRQ_MTI      = 7;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } state_e;

endpackage

// File: rtl/trap_controller_csr_regfile.sv
// Purpose: M-mode CSR storage, read mux, RW/RS/RC update, trap-entry and MRET side effects.
// Latency: read is combinational in the same cycle; writes and side effects land on the next edge.
// Backpressure: none; the caller qualifies wr_en_i/trap_i/mret_i, at most one of them acts.
// Ports: clk_i/rst_ni; wr_en_i, op_i, addr_i, wdata_i -> rdata_o (old value);
//        trap_i, trap_pc_i, trap_code_i, mret_i; mip_i (read-only view); mie_o, mstatus_mie_o, mtvec_o, mepc_o.
module trap_controller_csr_regfile
  import trap_controller_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  csr_op_e           op_i,
  input  logic [11:0]       addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o,
  input  logic              trap_i,
  input  logic [XLEN-1:2]   trap_pc_i,
  input  logic [3:0]        trap_code_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   mip_i,
  output logic [XLEN-1:0]   mie_o,
  output logic              mstatus_mie_o,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o
);

  // Only the architecturally writable bits are stored
  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic            meie_q, meie_d;
  logic            mtie_q, mtie_d;
  logic [XLEN-1:2] mtvec_q, mtvec_d;
  logic [XLEN-1:2] mepc_q, mepc_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] wval;

  always_comb begin
    mstatus_val               = '0;
    mstatus_val[MSTATUS_MIE]  = mst_mie_q;
    mstatus_val[MSTATUS_MPIE] = mst_mpie_q;
    mie_o                     = '0;
    mie_o[IRQ_MEI]            = meie_q;
    mie_o[IRQ_MTI]            = mtie_q;
  end

  assign mstatus_mie_o = mst_mie_q;
  assign mtvec_o       = {mtvec_q, 2'b00};
  assign mepc_o        = {mepc_q, 2'b00};

  always_comb begin
    case (addr_i)
      CSR_MSTATUS:  rdata_o = mstatus_val;
      CSR_MIE:      rdata_o = mie_o;
      CSR_MTVEC:    rdata_o = mtvec_o;
      CSR_MSCRATCH: rdata_o = mscratch_q;
      CSR_MEPC:     rdata_o = mepc_o;
      CSR_MCAUSE:   rdata_o = mcause_q;
      CSR_MIP:      rdata_o = mip_i;
      default:      rdata_o = '0;
    endcase
  end

  // RS/RC with wdata=0 rewrite the old value, which is the same as not writing
  always_comb begin
    case (op_i)
      CSR_OP_RW: wval = wdata_i;
      CSR_OP_RS: wval = rdata_o | wdata_i;
      CSR_OP_RC: wval = rdata_o & ~wdata_i;
      default:   wval = rdata_o;
    endcase
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    if (trap_i) begin
      mepc_d         = trap_pc_i;
      mcause_d       = '0;
      mcause_d[XLEN-1] = 1'b1;
      mcause_d[3:0]  = trap_code_i;
      mst_mpie_d     = mst_mie_q;
      mst_mie_d      = 1'b0;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en_i) begin
      case (addr_i)
        CSR_MSTATUS: begin
          mst_mie_d  = wval[MSTATUS_MIE];
          mst_mpie_d = wval[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          meie_d = wval[IRQ_MEI];
          mtie_d = wval[IRQ_MTI];
        end
        CSR_MTVEC:    mtvec_d    = wval[XLEN-1:2];
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval[XLEN-1:2];
        CSR_MCAUSE:   mcause_d   = wval;
        default:      ; // mip and unmapped addresses ignore writes
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET[XLEN-1:2];
      mepc_q     <= '0;
      mscratch_q <= '0;
      mcause_q   <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      meie_q     <= meie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
    end
  end

  logic unused_mtvec_lsb;
  assign unused_mtvec_lsb = ^MTVEC_RESET[1:0];

endmodule

// File: rtl/trap_controller.sv
// Purpose: M-mode trap/return unit: irq sync, take/ret/csr/wfi priority, RUN/SLEEP FSM, PC redirect.
// Latency: redirect/csr_rdata combinational; irq visible 2 cycles after assert; stall drops 1 cycle after wake.
// Backpressure: stall_o freezes the core while sleeping; retiring instructions are ignored in SLEEP.
// Ports: clk_i, rst_ni; instr_valid_i, pc_i, csr_w_en_i, ret_i, wfi_i, funct3_i, csr_addr_i, csr_wdata_i;
//        ext_irq_i, timer_irq_i (async levels); csr_rdata_o, redirect_en_o, redirect_pc_o, stall_o, irq_taken_o.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            csr_w_en_i,
  input  logic            ret_i,
  input  logic            wfi_i,
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            ext_irq_i,
  input  logic            timer_irq_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            redirect_en_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            stall_o,
  output logic            irq_taken_o
);

  logic [1:0]      ext_sync_q, tmr_sync_q;
  state_e          state_q;
  logic            stall_q;

  logic [XLEN-1:0] mip, mie, pend, mtvec, mepc, csr_rd;
  logic            mstatus_mie, pend_any, run;
  logic            take, do_ret, do_csr, do_wfi;
  logic [3:0]      cause;

  // Two-flop synchronisers for the asynchronous interrupt levels
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ext_sync_q <= 2'b00;
      tmr_sync_q <= 2'b00;
    end else begin
      ext_sync_q <= {ext_sync_q[0], ext_irq_i};
      tmr_sync_q <= {tmr_sync_q[0], timer_irq_i};
    end
  end

  always_comb begin
    mip          = '0;
    mip[IRQ_MEI] = ext_sync_q[1];
    mip[IRQ_MTI] = tmr_sync_q[1];
  end

  assign pend     = mip & mie;
  assign pend_any = |pend;
  assign run      = (state_q == ST_RUN);

  // One action per retiring instruction: take > ret > csr > wfi
  assign take   = run & instr_valid_i & mstatus_mie & pend_any;
  assign do_ret = run & instr_valid_i & ret_i & ~take;
  assign do_csr = run & instr_valid_i & csr_w_en_i & ~take & ~ret_i;
  assign do_wfi = run & instr_valid_i & wfi_i & ~take & ~ret_i & ~csr_w_en_i;
  assign cause  = pend[IRQ_MEI] ? CAUSE_MEI : CAUSE_MTI;

  trap_controller_csr_regfile #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_en_i       (do_csr),
    .op_i          (csr_op_e'(funct3_i[1:0])),
    .addr_i        (csr_addr_i),
    .wdata_i       (csr_wdata_i),
    .rdata_o       (csr_rd),
    .trap_i        (take),
    .trap_pc_i     (pc_i[XLEN-1:2]),
    .trap_code_i   (cause),
    .mret_i        (do_ret),
    .mip_i         (mip),
    .mie_o         (mie),
    .mstatus_mie_o (mstatus_mie),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc)
  );

  assign csr_rdata_o   = csr_w_en_i ? csr_rd : '0;
  assign redirect_en_o = take | do_ret;
  assign redirect_pc_o = take ? mtvec : (do_ret ? mepc : '0);
  assign irq_taken_o   = take;
  assign stall_o       = stall_q;

  // Wake ignores mstatus.MIE: the held instruction then retires or traps in RUN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      stall_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (do_wfi && !pend_any) begin
        state_q <= ST_SLEEP;
        stall_q <= 1'b1;
      end
    end else begin
      if (pend_any) begin
        state_q <= ST_RUN;
        stall_q <= 1'b0;
      end
    end
  end

  logic unused_in_bits;
  assign unused_in_bits = ^{pc_i[1:0], funct3_i[2]};

endmodule

// File: tb/tb_trap_controller.sv
// Purpose: directed stimulus for trap_controller with a queue-based scoreboard and an independent monitor.
// Latency: stimulus applied 1 time unit after posedge; monitor samples on negedge of the same cycle.
// Backpressure: stimulus is scripted; stall timing is checked against expected cycle numbers.
module tb_trap_controller;

  localparam logic [2:0] F_RW  = 3'b001;
  localparam logic [2:0] F_RS  = 3'b010;
  localparam logic [2:0] F_RC  = 3'b011;
  localparam logic [2:0] F_RWI = 3'b101;
  localparam logic [2:0] F_RSI = 3'b110;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        csr_w_en_i, ret_i, wfi_i;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        ext_irq_i, timer_irq_i;
  logic [31:0] csr_rdata_o;
  logic        redirect_en_o;
  logic [31:0] redirect_pc_o;
  logic        stall_o, irq_taken_o;

  trap_controller dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_valid_i (instr_valid_i),
    .pc_i          (pc_i),
    .csr_w_en_i    (csr_w_en_i),
    .ret_i         (ret_i),
    .wfi_i         (wfi_i),
    .funct3_i      (funct3_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wdata_i   (csr_wdata_i),
    .ext_irq_i     (ext_irq_i),
    .timer_irq_i   (timer_irq_i),
    .csr_rdata_o   (csr_rdata_o),
    .redirect_en_o (redirect_en_o),
    .redirect_pc_o (redirect_pc_o),
    .stall_o       (stall_o),
    .irq_taken_o   (irq_taken_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic val;
    int   cyc;
  } stall_exp_t;

  logic [31:0] rd_q[$];
  string       rd_tag_q[$];
  logic [32:0] rdr_q[$];
  string       rdr_tag_q[$];
  stall_exp_t  stall_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin : mon
    logic [32:0] e;
    logic [31:0] r;
    string       t;
    stall_exp_t  s;
    if (mon_en) begin
      if (redirect_en_o) begin
        n_cmp++;
        if (rdr_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_redirect cyc=%0d: got pc=%h taken=%b, required no redirect",
                   cyc, redirect_pc_o, irq_taken_o);
        end else begin
          e = rdr_q.pop_front();
          t = rdr_tag_q.pop_front();
          if ({redirect_pc_o, irq_taken_o} !== e) begin
            n_bad++;
            $display("FAIL %s: got pc=%h taken=%b, required pc=%h taken=%b",
                     t, redirect_pc_o, irq_taken_o, e[32:1], e[0]);
          end
        end
      end else begin
        n_cmp++;
        if (irq_taken_o !== 1'b0) begin
          n_bad++;
          $display("FAIL irq_taken_without_redirect cyc=%0d: got %b, required 0", cyc, irq_taken_o);
        end
      end

      if (csr_w_en_i && !redirect_en_o) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_csr_read cyc=%0d: got %h, required no read", cyc, csr_rdata_o);
        end else begin
          r = rd_q.pop_front();
          t = rd_tag_q.pop_front();
          if (csr_rdata_o !== r) begin
            n_bad++;
            $display("FAIL %s: got rdata=%h, required %h", t, csr_rdata_o, r);
          end
        end
      end else if (!csr_w_en_i) begin
        n_cmp++;
        if (csr_rdata_o !== 32'h0) begin
          n_bad++;
          $display("FAIL rdata_idle cyc=%0d: got %h, required 0", cyc, csr_rdata_o);
        end
      end

      if (stall_o !== prev_stall) begin
        n_cmp++;
        if (stall_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_stall_change cyc=%0d: got stall=%b, required %b", cyc, stall_o, prev_stall);
        end else begin
          s = stall_q.pop_front();
          if (stall_o !== s.val || cyc != s.cyc) begin
            n_bad++;
            $display("FAIL stall_edge: got stall=%b at cyc %0d, required stall=%b at cyc %0d",
                     stall_o, cyc, s.val, s.cyc);
          end
        end
        prev_stall = stall_o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic v, input logic [31:0] pc, input logic csr, input logic rt,
                       input logic wf, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wd);
    instr_valid_i = v;
    pc_i          = pc;
    csr_w_en_i    = csr;
    ret_i         = rt;
    wfi_i         = wf;
    funct3_i      = f3;
    csr_addr_i    = addr;
    csr_wdata_i   = wd;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 12'h000, 32'h0);
  endtask

  task automatic nop(input logic [31:0] pc);
    issue(1'b1, pc, 1'b0, 1'b0, 1'b0, 3'b000, 12'h000, 32'h0);
  endtask

  task automatic wfi_at(input logic [31:0] pc);
    issue(1'b1, pc, 1'b0, 1'b0, 1'b1, 3'b000, 12'h000, 32'h0);
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input string tag);
    rd_q.push_back(exp);
    rd_tag_q.push_back(tag);
    issue(1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, f3, addr, wd);
  endtask

  task automatic expect_redir(input logic [31:0] pc, input logic taken, input string tag);
    rdr_q.push_back({pc, taken});
    rdr_tag_q.push_back(tag);
  endtask

  task automatic expect_stall(input logic v, input int c);
    stall_exp_t s;
    s.val = v;
    s.cyc = c;
    stall_q.push_back(s);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int k;
    rst_ni        = 1'b0;
    instr_valid_i = 1'b0;
    pc_i          = 32'h0;
    csr_w_en_i    = 1'b0;
    ret_i         = 1'b0;
    wfi_i         = 1'b0;
    funct3_i      = 3'b000;
    csr_addr_i    = 12'h000;
    csr_wdata_i   = 32'h0;
    ext_irq_i     = 1'b0;
    timer_irq_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({stall_o, redirect_en_o, irq_taken_o, csr_rdata_o, redirect_pc_o} !== 67'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got stall=%b redir=%b taken=%b rdata=%h rpc=%h, required all 0",
               stall_o, redirect_en_o, irq_taken_o, csr_rdata_o, redirect_pc_o);
    end
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // reset values
    csr_op(F_RS, 12'h300, 32'h0, 32'h0, "rst_mstatus");
    csr_op(F_RS, 12'h304, 32'h0, 32'h0, "rst_mie");
    csr_op(F_RS, 12'h344, 32'h0, 32'h0, "rst_mip");
    csr_op(F_RS, 12'h342, 32'h0, 32'h0, "rst_mcause");

    // CSR RW/RS/RC and masking
    csr_op(F_RW,  12'h305, 32'h0000_0203, 32'h0000_0100, "mtvec_rw_old");
    csr_op(F_RSI, 12'h305, 32'h0,         32'h0000_0200, "mtvec_rs0");
    csr_op(F_RW,  12'h304, 32'h0000_0880, 32'h0,         "mie_rw_old");
    csr_op(F_RC,  12'h304, 32'h0000_0080, 32'h0000_0880, "mie_rc_old");
    csr_op(F_RS,  12'h304, 32'h0,         32'h0000_0800, "mie_after_rc");
    csr_op(F_RWI, 12'h300, 32'hFFFF_FFFF, 32'h0,         "mstatus_rw_old");
    csr_op(F_RS,  12'h300, 32'h0,         32'h0000_0088, "mstatus_mask");

    // external interrupt: visible 2 cycles after assert
    ext_irq_i = 1'b1;
    nop(32'h38);
    nop(32'h3C);
    expect_redir(32'h0000_0200, 1'b1, "ext_trap");
    nop(32'h40);
    ext_irq_i = 1'b0;
    idle(3);
    csr_op(F_RS, 12'h341, 32'h0, 32'h0000_0040, "ext_mepc");
    csr_op(F_RS, 12'h342, 32'h0, 32'h8000_000B, "ext_mcause");
    csr_op(F_RS, 12'h300, 32'h0, 32'h0000_0080, "ext_mstatus");

    // MRET
    expect_redir(32'h0000_0040, 1'b0, "mret");
    issue(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 3'b000, 12'h000, 32'h0);
    csr_op(F_RS, 12'h300, 32'h0, 32'h0000_0088, "mret_mstatus");

    // simultaneous external + timer: external wins
    csr_op(F_RW, 12'h304, 32'h0000_0880, 32'h0000_0800, "mie_both");
    ext_irq_i   = 1'b1;
    timer_irq_i = 1'b1;
    nop(32'h48);
    nop(32'h4C);
    expect_redir(32'h0000_0200, 1'b1, "both_trap");
    nop(32'h50);
    ext_irq_i   = 1'b0;
    timer_irq_i = 1'b0;
    idle(3);
    csr_op(F_RS, 12'h342, 32'h0, 32'h8000_000B, "both_mcause");
    csr_op(F_RS, 12'h341, 32'h0, 32'h0000_0050, "both_mepc");

    // WFI sleep, timer wake with MIE=0: no trap
    k = cyc;
    expect_stall(1'b1, k + 1);
    wfi_at(32'h60);
    repeat (10) nop(32'h64);
    timer_irq_i = 1'b1;
    k = cyc;
    expect_stall(1'b0, k + 3);
    repeat (3) nop(32'h64);
    nop(32'h64);
    // WFI with an interrupt already pending behaves as a NOP
    wfi_at(32'h68);
    nop(32'h6C);
    timer_irq_i = 1'b0;
    idle(3);

    // WFI sleep, timer wake with MIE=1: held instruction traps
    csr_op(F_RS, 12'h300, 32'h0000_0008, 32'h0000_0080, "set_mie_4b");
    k = cyc;
    expect_stall(1'b1, k + 1);
    wfi_at(32'h70);
    repeat (10) nop(32'h74);
    timer_irq_i = 1'b1;
    k = cyc;
    expect_stall(1'b0, k + 3);
    repeat (3) nop(32'h74);
    expect_redir(32'h0000_0200, 1'b1, "wfi_wake_trap");
    nop(32'h74);
    timer_irq_i = 1'b0;
    idle(3);
    csr_op(F_RS, 12'h341, 32'h0, 32'h0000_0074, "wfi_mepc");
    csr_op(F_RS, 12'h342, 32'h0, 32'h8000_0007, "timer_mcause");

    // interrupt squashes a same-cycle CSR write
    csr_op(F_RW, 12'h340, 32'h1234_5678, 32'h0, "mscratch_rw");
    csr_op(F_RS, 12'h300, 32'h0000_0008, 32'h0000_0080, "set_mie_5");
    ext_irq_i = 1'b1;
    nop(32'h88);
    nop(32'h8C);
    expect_redir(32'h0000_0200, 1'b1, "squash_trap");
    issue(1'b1, 32'h90, 1'b1, 1'b0, 1'b0, F_RW, 12'h340, 32'hDEAD_BEEF);
    ext_irq_i = 1'b0;
    idle(3);
    csr_op(F_RS, 12'h340, 32'h0, 32'h1234_5678, "mscratch_kept");
    csr_op(F_RW, 12'h7C0, 32'hFFFF_FFFF, 32'h0, "unmapped_w");
    csr_op(F_RS, 12'h7C0, 32'h0, 32'h0, "unmapped_r");

    // reset while sleeping
    k = cyc;
    expect_stall(1'b1, k + 1);
    wfi_at(32'hA0);
    repeat (4) nop(32'hA4);
    rst_ni = 1'b0;
    k = cyc;
    expect_stall(1'b0, k + 1);
    nop(32'hA4);
    rst_ni = 1'b1;
    csr_op(F_RS, 12'h300, 32'h0, 32'h0,           "rst2_mstatus");
    csr_op(F_RS, 12'h304, 32'h0, 32'h0,           "rst2_mie");
    csr_op(F_RS, 12'h305, 32'h0, 32'h0000_0100,   "rst2_mtvec");
    csr_op(F_RS, 12'h340, 32'h0, 32'h0,           "rst2_mscratch");
    csr_op(F_RS, 12'h341, 32'h0, 32'h0,           "rst2_mepc");
    csr_op(F_RS, 12'h342, 32'h0, 32'h0,           "rst2_mcause");
    idle(2);
    mon_en = 1'b0;

    // every queued expectation must have been consumed
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_csr_reads: got %0d left, required 0", rd_q.size());
    end
    n_cmp++;
    if (rdr_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_redirects: got %0d left, required 0", rdr_q.size());
    end
    n_cmp++;
    if (stall_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_stall_edges: got %0d left, required 0", stall_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
